fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 32, PC and instruction-memory address width.
REQ-002 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 Parameter RESET_PC, default 0, PC value loaded by reset.
REQ-004 Parameter PC_STEP, default 4, PC increment per sequential fetch.
REQ-005 Parameter DEPTH, default 2, fetch-queue entries, SHALL be >= 2.
REQ-006 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 pc_o  output  ADDRESS_WIDTH  current fetch PC, drives instr_mem PC input.
REQ-009 instr_i  input  DATA_WIDTH  instruction returned combinationally by instr_mem for pc_o.
REQ-010 redirect_i  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc_i  input  ADDRESS_WIDTH  target PC, sampled when redirect_i=1.
REQ-012 out_valid_o  output  1  head queue entry valid for decode.
REQ-013 out_ready_i  input  1  decode accepts head entry.
REQ-014 out_pc_o  output  ADDRESS_WIDTH  PC of head entry.
REQ-015 out_instr_o  output  DATA_WIDTH  instruction of head entry.

Function
REQ-016 pc_o SHALL equal the PC register, with no combinational path from any input.
REQ-017 pop SHALL be defined as out_valid_o && out_ready_i; transfer occurs on that edge.
REQ-018 push SHALL occur in any cycle with redirect_i=0 and (count < DEPTH or pop); push writes {pc_o, instr_i} at tail and PC <= PC + PC_STEP.
REQ-019 No push (queue full, no pop): PC SHALL hold and be re-presented the next cycle.
REQ-020 PC addition SHALL be modulo 2^ADDRESS_WIDTH (all-ones region wraps to low addresses, no flag).
REQ-021 Queue SHALL be FIFO: circular head/tail pointers modulo DEPTH plus occupancy count 0..DEPTH.
REQ-022 out_valid_o SHALL be 1 iff count != 0; out_pc_o/out_instr_o SHALL come from head entry registers, not from instr_i.
REQ-023 Simultaneous push and pop SHALL leave count unchanged, including when count == DEPTH.
REQ-024 Pop with no push SHALL decrement count; push with no pop SHALL increment count.
REQ-025 out_pc_o/out_instr_o SHALL remain stable while out_valid_o=1 and out_ready_i=0.
REQ-026 redirect_i=1 SHALL, on that edge, set count to 0, reset pointers, load PC <= redirect_pc_i, and suppress push; redirect SHALL take priority over push and pop in the same cycle.
REQ-027 Cycle after redirect: out_valid_o=0, pc_o=redirect_pc_i; first redirected entry SHALL appear at out_valid_o one cycle later (redirect-to-valid latency 2 edges).
REQ-028 Back-to-back redirects SHALL each take effect; only the last target is fetched.
REQ-029 redirect_pc_i alignment SHALL NOT be checked; value passes through unmodified.
REQ-030 Steady-state throughput with out_ready_i held 1 SHALL be one instruction per cycle.

Reset
REQ-031 rst=1 on an edge SHALL set PC=RESET_PC, count=0, pointers=0; rst overrides redirect_i, push and pop.
REQ-032 During and in the cycle after reset: out_valid_o=0, pc_o=RESET_PC; out_pc_o/out_instr_o reset to 0.
REQ-033 Reset asserted mid-stream SHALL discard all queued entries; first post-reset entry SHALL be PC=RESET_PC.

Verification
REQ-034 Release reset, out_ready_i=1, memory word k = 0x1000+k -> out_valid_o rises 1 cycle after release; outputs (0x0,0x1000),(0x4,0x1001),(0x8,0x1002)... one per cycle.
REQ-035 out_ready_i=0 for 5 cycles after reset -> count reaches 2, pc_o holds 0x8, head stays (0x0,0x1000); out_ready_i=1 -> (0x0),(0x4),(0x8) in consecutive cycles, no gap, no duplicate.
REQ-036 Queue full, out_ready_i=1 -> push and pop same cycle, count stays 2, PC advances 4 per cycle.
REQ-037 redirect_i=1, redirect_pc_i=0x40 while queue holds 2 entries and out_ready_i=1 -> next cycle out_valid_o=0, pc_o=0x40; following cycle out_pc_o=0x40; no pre-redirect PC emitted afterward.
REQ-038 RESET_PC=0xFFFFFFFC, out_ready_i=1 -> out_pc_o sequence 0xFFFFFFFC, 0x00000000, 0x00000004.
REQ-039 rst=1 with redirect_i=1 and full queue -> next cycle count=0, out_valid_o=0, pc_o=RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Sequential instruction fetch front end. A PC register drives the
// instruction memory address (pc_o); the memory answers combinationally on
// instr_i. Each cycle the {pc, instr} pair is pushed into a small circular
// fetch queue whenever there is room (or room is being made by a pop this
// cycle), and the PC advances by PC_STEP. Decode drains the queue head
// through a valid/ready port. A redirect flushes the queue and restarts
// fetch at the target PC.
//
// Parameters
//   ADDRESS_WIDTH  PC / instruction-memory address width
//   DATA_WIDTH     instruction word width
//   RESET_PC       PC loaded by reset
//   PC_STEP        PC increment per sequential fetch (wraps modulo 2^AW)
//   DEPTH          fetch-queue entries, must be >= 2
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   pc_o           current fetch PC (registered, no input-to-output path)
//   instr_i        instruction returned by the memory for pc_o
//   redirect_i     taken branch/jump: flush queue, refetch at redirect_pc_i
//   redirect_pc_i  redirect target, passed through unmodified
//   out_valid_o    queue head holds a valid entry
//   out_ready_i    decode accepts the head entry
//   out_pc_o       PC of the head entry
//   out_instr_o    instruction of the head entry
//
// Handshake: a transfer on the decode port happens on the rising edge where
// out_valid_o && out_ready_i. While out_valid_o is high and out_ready_i is
// low, out_pc_o/out_instr_o hold their values; out_valid_o never drops
// without a transfer except on redirect or reset.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int                         ADDRESS_WIDTH = 32,
  parameter int                         DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0]   RESET_PC      = '0,
  parameter logic [ADDRESS_WIDTH-1:0]   PC_STEP       = ADDRESS_WIDTH'(4),
  parameter int                         DEPTH         = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDRESS_WIDTH-1:0]  pc_o,
  input  logic [DATA_WIDTH-1:0]     instr_i,
  input  logic                      redirect_i,
  input  logic [ADDRESS_WIDTH-1:0]  redirect_pc_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [ADDRESS_WIDTH-1:0]  out_pc_o,
  output logic [DATA_WIDTH-1:0]     out_instr_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [ADDRESS_WIDTH-1:0] pc_q,    pc_d;
  logic [PTR_W-1:0]         head_q,  head_d;
  logic [PTR_W-1:0]         tail_q,  tail_d;
  logic [CNT_W-1:0]         count_q, count_d;

  // Queue storage, one {pc, instr} pair per entry.
  logic [ADDRESS_WIDTH-1:0] ent_pc_q    [DEPTH];
  logic [DATA_WIDTH-1:0]    ent_instr_q [DEPTH];

  // -------------------------------------------------------------------------
  // Handshake decode
  // -------------------------------------------------------------------------
  logic pop;
  logic push;
  logic not_full;

  assign out_valid_o = (count_q != '0);
  assign not_full    = (count_q < CNT_DEPTH);
  assign pop         = out_valid_o && out_ready_i;
  // A full queue still accepts a push when the head leaves on the same
  // edge, which is what sustains one instruction per cycle.
  assign push        = !redirect_i && (not_full || pop);

  // -------------------------------------------------------------------------
  // Pointer helpers: circular increment modulo DEPTH (DEPTH need not be a
  // power of two, so wrap explicitly).
  // -------------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + 1'b1;
    end
  endfunction

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (redirect_i) begin
      // Redirect wins over any push/pop this cycle: everything in the queue
      // belongs to the wrong path.
      pc_d    = redirect_pc_i;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        pc_d   = pc_q + PC_STEP;  // modulo 2^ADDRESS_WIDTH by truncation
        tail_d = ptr_inc(tail_q);
      end
      if (pop) begin
        head_d = ptr_inc(head_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is cleared on reset so the head outputs read as zero
  // while the queue is empty after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc_q[i]    <= '0;
        ent_instr_q[i] <= '0;
      end
    end else if (push) begin
      ent_pc_q[tail_q]    <= pc_q;
      ent_instr_q[tail_q] <= instr_i;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign pc_o        = pc_q;
  assign out_pc_o    = ent_pc_q[head_q];
  assign out_instr_o = ent_instr_q[head_q];

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. Main instance uses RESET_PC=0 with a
// memory model returning 0x1000 + (pc >> 2). A second instance with
// RESET_PC=0xFFFFFFFC, decode always ready, checks PC wrap-around.
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// the same point, i.e. they reflect the state after that edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Main DUT
  // ---------------------------------------------------------------------
  logic [31:0] pc;
  logic [31:0] instr;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  assign instr = 32'h1000 + {2'b00, pc[31:2]};

  fetch_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'h0),
    .PC_STEP       (32'h4),
    .DEPTH         (2)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .pc_o          (pc),
    .instr_i       (instr),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .out_valid_o   (out_valid),
    .out_ready_i   (out_ready),
    .out_pc_o      (out_pc),
    .out_instr_o   (out_instr)
  );

  // ---------------------------------------------------------------------
  // Wrap-around DUT
  // ---------------------------------------------------------------------
  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic        w_valid;
  logic [31:0] w_out_pc;
  logic [31:0] w_out_instr;

  assign w_instr = ~w_pc;

  fetch_unit #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .RESET_PC      (32'hFFFF_FFFC),
    .PC_STEP       (32'h4),
    .DEPTH         (2)
  ) u_wrap (
    .clk           (clk),
    .rst           (rst),
    .pc_o          (w_pc),
    .instr_i       (w_instr),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .out_valid_o   (w_valid),
    .out_ready_i   (1'b1),
    .out_pc_o      (w_out_pc),
    .out_instr_o   (w_out_instr)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Check the head entry of the main DUT.
  task automatic check_head(input string tag, input logic [31:0] exp_pc);
    check({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, ".pc"},    out_pc, exp_pc);
    check({tag, ".instr"}, out_instr, 32'h1000 + (exp_pc >> 2));
  endtask

  // ---------------------------------------------------------------------
  // Driver
  // ---------------------------------------------------------------------
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    step(2);
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    // Reset state
    out_ready = 1'b1;
    step(2);
    check("rst.valid",   {31'b0, out_valid}, 32'd0);
    check("rst.pc",      pc, 32'h0);
    check("rst.out_pc",  out_pc, 32'h0);
    check("rst.out_ins", out_instr, 32'h0);
    check("rst.wpc",     w_pc, 32'hFFFF_FFFC);
    check("rst.wvalid",  {31'b0, w_valid}, 32'd0);

    // Streaming, one per cycle, with the wrap instance alongside
    rst = 1'b0;
    step(1);
    check_head("s0", 32'h0);
    check("s0.pc", pc, 32'h4);
    check("w0.pc", w_out_pc, 32'hFFFF_FFFC);
    check("w0.in", w_out_instr, 32'h0000_0003);
    step(1);
    check_head("s1", 32'h4);
    check("w1.pc", w_out_pc, 32'h0);
    step(1);
    check_head("s2", 32'h8);
    check("w2.pc", w_out_pc, 32'h4);
    check("w2.v",  {31'b0, w_valid}, 32'd1);

    // Back-pressure: fill, hold, then drain without gaps
    do_reset();
    out_ready = 1'b0;
    step(5);
    check_head("bp.hold", 32'h0);
    check("bp.pc", pc, 32'h8);
    step(1);
    check_head("bp.stable", 32'h0);
    check("bp.pc2", pc, 32'h8);
    out_ready = 1'b1;
    step(1);
    check_head("bp.d1", 32'h4);
    check("bp.d1pc", pc, 32'hC);
    step(1);
    check_head("bp.d2", 32'h8);
    check("bp.d2pc", pc, 32'h10);
    step(1);
    check_head("bp.d3", 32'hC);
    check("bp.d3pc", pc, 32'h14);

    // Redirect with a full queue while decode is ready
    out_ready = 1'b0;
    step(2);
    out_ready   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step(1);
    redirect = 1'b0;
    check("rd.valid", {31'b0, out_valid}, 32'd0);
    check("rd.pc",    pc, 32'h40);
    step(1);
    check_head("rd.h0", 32'h40);
    step(1);
    check_head("rd.h1", 32'h44);

    // Back-to-back redirects; only the last (unaligned) target is fetched
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    step(1);
    redirect_pc = 32'h102;
    step(1);
    redirect = 1'b0;
    check("bb.valid", {31'b0, out_valid}, 32'd0);
    check("bb.pc",    pc, 32'h102);
    step(1);
    check_head("bb.h0", 32'h102);
    check("bb.pc2", pc, 32'h106);

    // Reset overrides redirect with a full queue, then restarts at RESET_PC
    out_ready = 1'b0;
    step(3);
    rst         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    step(1);
    check("rr.valid", {31'b0, out_valid}, 32'd0);
    check("rr.pc",    pc, 32'h0);
    check("rr.opc",   out_pc, 32'h0);
    rst       = 1'b0;
    redirect  = 1'b0;
    out_ready = 1'b1;
    step(1);
    check_head("rr.h0", 32'h0);
    step(1);
    check_head("rr.h1", 32'h4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
